// File: rtl/pmc_readout.sv
// pmc_readout: snapshots four performance-monitor metric buses and
// streams them as a framed, checksummed word sequence over valid/ready.
module pmc_readout #(
  parameter int          WORDS_PER_METRIC = 1,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0400
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_in,
  input  logic [255:0] stall_count_in,
  input  logic [255:0] cpi_q78_in,
  input  logic [255:0] arith_count_in,
  input  logic [255:0] mem_access_count_in,
  output logic [31:0]  word_out,
  output logic [31:0]  word_addr_out,
  output logic         word_valid_out,
  input  logic         word_ready_in,
  output logic         busy_out,
  output logic         done_out
);

  localparam int N    = 4 * WORDS_PER_METRIC;
  localparam int LAST = N + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [31:0]         csum_q, csum_d;
  logic [7:0]          seq_q, seq_d;
  logic [3:0][255:0]   snap_q, snap_d;
  logic [31:0]         cur_word;
  logic                accept;

  assign accept = (state_q == SEND) && word_ready_in;

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      seq_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
      snap_q  <= snap_d;
    end
  end

  // Select the frame word addressed by the current index.
  always_comb begin
    cur_word = '0;
    if (idx_q == 6'd0) begin
      cur_word = {16'h504D, seq_q, 8'(N)};
    end else if (idx_q == 6'(LAST)) begin
      cur_word = csum_q;
    end else begin
      for (int m = 0; m < 4; m++) begin
        for (int j = 0; j < WORDS_PER_METRIC; j++) begin
          if (idx_q == 6'(1 + m * WORDS_PER_METRIC + j)) begin
            cur_word = snap_q[m][32*j +: 32];
          end
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_in) state_d = SEND;
      SEND: if (accept && idx_q == 6'(LAST)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot capture, index advance, checksum fold and sequence count.
  always_comb begin
    snap_d = snap_q;
    idx_d  = idx_q;
    csum_d = csum_q;
    seq_d  = seq_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          snap_d[0] = stall_count_in;
          snap_d[1] = cpi_q78_in;
          snap_d[2] = arith_count_in;
          snap_d[3] = mem_access_count_in;
          idx_d     = '0;
          csum_d    = '0;
        end
      end
      SEND: begin
        if (accept) begin
          idx_d = idx_q + 6'd1;
          if (idx_q != 6'(LAST)) csum_d = csum_q ^ cur_word;
        end
      end
      DONE: begin
        seq_d = seq_q + 8'd1;
        idx_d = '0;
      end
      default: ;
    endcase
  end

  // Outputs are gated by state so IDLE and reset present all zeros.
  always_comb begin
    word_valid_out = (state_q == SEND);
    busy_out       = (state_q == SEND);
    done_out       = (state_q == DONE);
    word_out       = '0;
    word_addr_out  = '0;
    if (state_q == SEND) begin
      word_out      = cur_word;
      word_addr_out = BASE_ADDR + {24'd0, idx_q, 2'b00};
    end
  end

endmodule

// File: tb/tb_pmc_readout.sv
// tb_pmc_readout: scoreboard bench for pmc_readout, with a one-word and a
// two-word-per-metric instance.
module tb_pmc_readout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start1, start2;
  logic         ready1, ready2;
  logic [255:0] st, cp, ar, me;

  logic [31:0] w1, a1, w2, a2;
  logic        v1, b1, d1, v2, b2, d2;

  pmc_readout #(.WORDS_PER_METRIC(1)) dut1 (
    .clk(clk), .reset(reset), .start_in(start1),
    .stall_count_in(st), .cpi_q78_in(cp),
    .arith_count_in(ar), .mem_access_count_in(me),
    .word_out(w1), .word_addr_out(a1), .word_valid_out(v1),
    .word_ready_in(ready1), .busy_out(b1), .done_out(d1)
  );

  pmc_readout #(.WORDS_PER_METRIC(2)) dut2 (
    .clk(clk), .reset(reset), .start_in(start2),
    .stall_count_in(st), .cpi_q78_in(cp),
    .arith_count_in(ar), .mem_access_count_in(me),
    .word_out(w2), .word_addr_out(a2), .word_valid_out(v2),
    .word_ready_in(ready2), .busy_out(b2), .done_out(d2)
  );

  int total = 0;
  int passed = 0;

  logic [31:0] q1_w[$], q1_a[$], q2_w[$], q2_a[$];
  int hs1 = 0, hs2 = 0, done1 = 0, done2 = 0;
  logic [7:0] seq_m = 8'd0;

  logic        hold_v = 1'b0;
  logic [31:0] hold_w, hold_a;

  // Monitor for the one-word instance: scoreboard pops and hold checks.
  always @(negedge clk) begin
    logic [31:0] ew, ea;
    if (hold_v) begin
      total++;
      if (v1 === 1'b1 && w1 === hold_w && a1 === hold_a) passed++;
      else $display("FAIL hold: got v=%b %h@%h, want %h@%h",
                    v1, w1, a1, hold_w, hold_a);
    end
    if (v1 === 1'b1 && ready1 === 1'b1) begin
      hs1++;
      total++;
      if (q1_w.size() == 0) begin
        $display("FAIL stream1: unexpected word %h@%h", w1, a1);
      end else begin
        ew = q1_w.pop_front();
        ea = q1_a.pop_front();
        if (w1 === ew && a1 === ea) passed++;
        else $display("FAIL stream1: got %h@%h, want %h@%h",
                      w1, a1, ew, ea);
      end
    end
    hold_v = (v1 === 1'b1) && (ready1 === 1'b0);
    hold_w = w1;
    hold_a = a1;
    if (d1 === 1'b1) done1++;
  end

  // Monitor for the two-word instance.
  always @(negedge clk) begin
    logic [31:0] ew, ea;
    if (v2 === 1'b1 && ready2 === 1'b1) begin
      hs2++;
      total++;
      if (q2_w.size() == 0) begin
        $display("FAIL stream2: unexpected word %h@%h", w2, a2);
      end else begin
        ew = q2_w.pop_front();
        ea = q2_a.pop_front();
        if (w2 === ew && a2 === ea) passed++;
        else $display("FAIL stream2: got %h@%h, want %h@%h",
                      w2, a2, ew, ea);
      end
    end
    if (d2 === 1'b1) done2++;
  end

  // Reference frame model: pushes expected words and addresses.
  task automatic push_frame(input logic [7:0] sq, input int wpm);
    int n;
    logic [31:0] wd, cs, ad;
    logic [255:0] bus;
    n  = 4 * wpm;
    wd = {16'h504D, sq, 8'(n)};
    cs = wd;
    ad = 32'h400;
    if (wpm == 1) begin q1_w.push_back(wd); q1_a.push_back(ad); end
    else          begin q2_w.push_back(wd); q2_a.push_back(ad); end
    for (int m = 0; m < 4; m++) begin
      bus = (m == 0) ? st : (m == 1) ? cp : (m == 2) ? ar : me;
      for (int j = 0; j < wpm; j++) begin
        wd = bus[32*j +: 32];
        cs = cs ^ wd;
        ad = ad + 32'd4;
        if (wpm == 1) begin q1_w.push_back(wd); q1_a.push_back(ad); end
        else          begin q2_w.push_back(wd); q2_a.push_back(ad); end
      end
    end
    ad = ad + 32'd4;
    if (wpm == 1) begin q1_w.push_back(cs); q1_a.push_back(ad); end
    else          begin q2_w.push_back(cs); q2_a.push_back(ad); end
  endtask

  task automatic set_basic();
    st = 256'd5;
    cp = 256'h180;
    ar = 256'hA;
    me = 256'd3;
  endtask

  task automatic pulse_start1();
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  task automatic wait_done1(input int d0);
    for (int k = 0; k < 300 && done1 == d0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 0; start2 = 0; ready1 = 1; ready2 = 1;
    set_basic();
    #12;
    total++;
    if ({v1, b1, d1, w1, a1} === 67'd0 && {v2, b2, d2} === 3'd0) passed++;
    else $display("FAIL reset_outputs: v=%b b=%b d=%b w=%h a=%h, want 0",
                  v1, b1, d1, w1, a1);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    int d0, h0, nv;
    set_basic();
    ready1 = 1'b1;
    d0 = done1; h0 = hs1; nv = 0;
    push_frame(seq_m, 1);
    pulse_start1();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (d1 === 1'b1) break;
      if (v1 === 1'b1) nv++;
    end
    seq_m++;
    total++;
    if (nv == 6) passed++;
    else $display("FAIL basic_latency: got %0d valid cycles, want 6", nv);
    repeat (4) @(negedge clk);
    total++;
    if (done1 - d0 == 1 && hs1 - h0 == 6) passed++;
    else $display("FAIL basic_count: done=%0d hs=%0d, want 1 6",
                  done1 - d0, hs1 - h0);
  endtask

  task automatic test_backpressure();
    int d0, h0;
    logic pat [3];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
    set_basic();
    d0 = done1; h0 = hs1;
    push_frame(seq_m, 1);
    pulse_start1();
    for (int k = 0; k < 100 && done1 == d0; k++) begin
      ready1 = pat[k % 3];
      @(posedge clk); #1;
    end
    ready1 = 1'b1;
    seq_m++;
    repeat (3) @(negedge clk);
    total++;
    if (done1 - d0 == 1 && hs1 - h0 == 6) passed++;
    else $display("FAIL backpressure_count: done=%0d hs=%0d, want 1 6",
                  done1 - d0, hs1 - h0);
  endtask

  task automatic test_snapshot();
    int d0;
    set_basic();
    ready1 = 1'b1;
    d0 = done1;
    push_frame(seq_m, 1);
    pulse_start1();
    st = {8{32'hFFFF_FFFF}};
    cp = {8{32'hFFFF_FFFF}};
    ar = {8{32'hFFFF_FFFF}};
    me = {8{32'hFFFF_FFFF}};
    wait_done1(d0);
    seq_m++;
    total++;
    if (done1 - d0 == 1) passed++;
    else $display("FAIL snapshot_done: got %0d pulses, want 1", done1 - d0);
    set_basic();
  endtask

  task automatic test_back_to_back();
    int d0, h0;
    set_basic();
    ready1 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      d0 = done1;
      push_frame(seq_m, 1);
      pulse_start1();
      wait_done1(d0);
      seq_m++;
    end
    d0 = done1; h0 = hs1;
    push_frame(seq_m, 1);
    pulse_start1();
    repeat (2) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1(d0);
    seq_m++;
    repeat (12) @(negedge clk);
    total++;
    if (done1 - d0 == 1 && hs1 - h0 == 6) passed++;
    else $display("FAIL ignore_start: done=%0d hs=%0d, want 1 6",
                  done1 - d0, hs1 - h0);
  endtask

  task automatic test_seq_wrap();
    int d0;
    set_basic();
    ready1 = 1'b1;
    for (int f = 0; f < 256 && seq_m != 8'd0; f++) begin
      d0 = done1;
      push_frame(seq_m, 1);
      pulse_start1();
      wait_done1(d0);
      seq_m++;
    end
    d0 = done1;
    push_frame(seq_m, 1);
    pulse_start1();
    @(negedge clk);
    total++;
    if (v1 === 1'b1 && w1 === 32'h504D_0004) passed++;
    else $display("FAIL seq_wrap: got v=%b %h, want 504d0004", v1, w1);
    wait_done1(d0);
    seq_m++;
  endtask

  task automatic test_multi_word();
    int h0;
    st = {192'd0, 32'h1, 32'h2};
    cp = 256'h180; ar = 256'hA; me = 256'd3;
    h0 = hs2;
    push_frame(8'd0, 2);
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int k = 0; k < 50 && d2 !== 1'b1; k++) @(negedge clk);
    total++;
    if (hs2 - h0 == 10 && q2_w.size() == 0) passed++;
    else $display("FAIL multi_word: hs=%0d left=%0d, want 10 0",
                  hs2 - h0, q2_w.size());
    set_basic();
  endtask

  task automatic test_reset_mid();
    int d0, h0;
    set_basic();
    ready1 = 1'b1;
    d0 = done1; h0 = hs1;
    push_frame(seq_m, 1);
    pulse_start1();
    for (int k = 0; k < 20 && hs1 - h0 < 3; k++) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    total++;
    if ({v1, b1, d1, w1, a1} === 67'd0) passed++;
    else $display("FAIL reset_mid: v=%b b=%b d=%b w=%h a=%h, want 0",
                  v1, b1, d1, w1, a1);
    q1_w.delete();
    q1_a.delete();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    seq_m = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if (done1 == d0) passed++;
    else $display("FAIL reset_no_done: got %0d pulses, want 0", done1 - d0);
    push_frame(seq_m, 1);
    pulse_start1();
    @(negedge clk);
    total++;
    if (w1 === 32'h504D_0004) passed++;
    else $display("FAIL reset_seq: got %h, want 504d0004", w1);
    wait_done1(d0);
    seq_m++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_multi_word();
    test_seq_wrap();
    test_reset_mid();
    repeat (4) @(negedge clk);
    total++;
    if (q1_w.size() == 0 && q2_w.size() == 0) passed++;
    else $display("FAIL drain: %0d/%0d words left, want 0",
                  q1_w.size(), q2_w.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pmc_readout.md
Name: pmc_readout

Overview:
- Reader side of the performance-monitor counter interface: consumes the four 256-bit metric buses (stall count, CPI in Q7.8, arithmetic count, memory-access count).
- On a start request, takes an atomic snapshot of all four buses, then streams a framed sequence of 32-bit words over a valid/ready port.
- The stream feeds a data-memory writer or a debug/UART bridge; each word carries a byte address for direct memory placement.

Parameters:
- WORDS_PER_METRIC, 1, number of 32-bit words emitted per metric (1..8), least-significant word first.
- BASE_ADDR, 32'h0000_0400, byte address of the frame's first word; word i is placed at BASE_ADDR + 4*i.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_in  input  1  snapshot-and-send request, sampled in IDLE only.
- stall_count_in  input  256  stall counter metric.
- cpi_q78_in  input  256  cycles-per-instruction metric, Q7.8 in bits [15:0].
- arith_count_in  input  256  arithmetic operation counter metric.
- mem_access_count_in  input  256  memory access counter metric.
- word_out  output  32  current stream word.
- word_addr_out  output  32  byte address of word_out.
- word_valid_out  output  1  word_out/word_addr_out valid.
- word_ready_in  input  1  consumer accepts the word when high with valid at a rising edge.
- busy_out  output  1  frame in progress (SEND state).
- done_out  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Snapshot registers, word index, checksum and sequence number all 0.
- Frame layout: N = 4*WORDS_PER_METRIC data words, total N+2 words.
  - Word 0, header: {16'h504D, seq[7:0], N[7:0]}.
  - Words 1..N: metrics in order stall, cpi, arith, mem_access. Within each metric, word j is bits [32j+31:32j], j = 0..WORDS_PER_METRIC-1.
  - Word N+1, checksum: XOR of words 0..N.
- FSM states and transitions:
  - IDLE: when start_in=1 at an edge, latch all four buses into snapshot registers and go to SEND at index 0. Inputs are never sampled again during the frame.
  - SEND: word_valid_out=1 and busy_out=1.
    - word_out and word_addr_out are a registered/combinational function of the index and snapshot, and stay stable while valid is high and ready is low.
    - On valid&ready, fold the word into the running checksum (checksum word excluded) and increment the index.
    - If the accepted index is N+1, go to DONE.
  - DONE: word_valid_out=0, busy_out=0, done_out=1 for exactly one cycle. seq increments (8-bit, wraps 255 to 0). Return to IDLE.
- Latency: first word is valid one cycle after start is sampled. With ready held high, one word is accepted per cycle. done_out asserts in the cycle after the last acceptance.
- Back-pressure: word_ready_in low holds the current word indefinitely; nothing is skipped or duplicated.
- start_in while in SEND or DONE is ignored and is not queued.
- Checksum register clears on entry to SEND.
- Reset asserted mid-frame:
  - Immediately returns to IDLE with all outputs 0 and seq=0.
  - The partial frame is abandoned and no done_out pulse is produced.
- Input buses changing during SEND have no effect on word_out.

Test Plan:
- Basic frame (W=1, ready=1): stall=5, cpi=0x0180, arith=0xA, mem=3, start pulse.
  - Required words: 0x504D0004, 0x5, 0x180, 0xA, 0x3, 0x504D0188.
  - Required addresses: 0x400, 0x404 ... 0x414.
  - done_out pulses once, 6 cycles after the first valid.
- Back-pressure: same stimulus, ready toggled 1,0,0,1,...
  - Each word is held stable across the stall cycles.
  - Exactly 6 handshakes occur; words match the basic frame.
- Snapshot isolation: change all metric inputs to 0xFFFF_FFFF in the cycle after start.
  - Stream still carries 5, 0x180, 0xA, 0x3.
- Sequence and ignore:
  - Run two frames back-to-back; headers are 0x504D0004 then 0x504D0104.
  - A start pulse during SEND produces no extra frame.
  - After 256 frames the header seq wraps to 0x00.
- Multi-word (W=2): stall bus = {…, 32'h1, 32'h2}.
  - Header is 0x504D0008.
  - Word 1 = 0x2, word 2 = 0x1; 10 words total.
  - Last word address = 0x424.
- Reset mid-frame: assert reset after word 2 is accepted.
  - All outputs go to 0 asynchronously, with no done_out pulse.
  - The next frame's header shows seq 0x00.
